// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and elaboration-time geometry/threshold checks for fifo_sync_flags
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ADDR  = 4;
  localparam int DEF_AF_TH = 14;
  localparam int DEF_AE_TH = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic bit depth_ok(input int depth, input int addr);
    return (depth >= 4) && ((1 << addr) == depth) && (clog2(depth) == addr);
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af_th, input int ae_th);
    return (af_th >= 1) && (af_th <= depth) && (ae_th >= 0) && (ae_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - dual-port RAM, registered write, registered or asynchronous read port
module fifo_mem_dp #(
  parameter int WIDTH    = 8,
  parameter int ADDR     = 4,
  parameter bit ASYNC_RD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (ASYNC_RD) begin : g_async_rd
      assign rdata = mem[raddr];
    end else begin : g_sync_rd
      logic [WIDTH-1:0] rdata_q;
      // Non-blocking read returns the old word when a write hits the same slot.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - parametrised sync FIFO with registered flags, count, sticky errors; FIFO_SYNC_FWFT_EN selects fall-through reads
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int MEMORY_WIDTH    = DEF_WIDTH,
  parameter int MEMORY_DEPTH    = DEF_DEPTH,
  parameter int ADDRESS_SIZE    = DEF_ADDR,
  parameter int ALMOST_FULL_TH  = DEF_AF_TH,
  parameter int ALMOST_EMPTY_TH = DEF_AE_TH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    rvalid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  generate
    if (!depth_ok(MEMORY_DEPTH, ADDRESS_SIZE)) begin : g_bad_geometry
      $error("fifo_sync_flags: MEMORY_DEPTH must be a power of two >= 4 and ADDRESS_SIZE its log2");
    end
    if (!thresholds_ok(MEMORY_DEPTH, ALMOST_FULL_TH, ALMOST_EMPTY_TH)) begin : g_bad_thresholds
      $error("fifo_sync_flags: almost_full/almost_empty threshold out of range");
    end
  endgenerate

`ifdef FIFO_SYNC_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  localparam logic [ADDRESS_SIZE:0] DEPTH_C = MEMORY_DEPTH[ADDRESS_SIZE:0];
  localparam logic [ADDRESS_SIZE:0] AF_C    = ALMOST_FULL_TH[ADDRESS_SIZE:0];
  localparam logic [ADDRESS_SIZE:0] AE_C    = ALMOST_EMPTY_TH[ADDRESS_SIZE:0];
  localparam logic [ADDRESS_SIZE:0] ONE_C   = {{ADDRESS_SIZE{1'b0}}, 1'b1};

  logic [ADDRESS_SIZE:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic full_q, empty_q, af_q, ae_q, rvalid_q, ovf_q, udf_q, ovf_d, udf_d;
  logic wr_acc, rd_acc;
  logic [MEMORY_WIDTH-1:0] mem_rdata;

  assign rd_acc = r_en & ~empty_q;
  assign wr_acc = w_en & (~full_q | rd_acc);

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Sticky errors: a new set condition beats a simultaneous clear.
  assign ovf_d = (w_en & ~wr_acc) | (ovf_q & ~clr_err);
  assign udf_d = (r_en & empty_q) | (udf_q & ~clr_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ONE_C;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ONE_C;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      rvalid_q <= FWFT ? (count_d != '0) : rd_acc;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH    (MEMORY_WIDTH),
    .ADDR     (ADDRESS_SIZE),
    .ASYNC_RD (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDRESS_SIZE-1:0]),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDRESS_SIZE-1:0]),
    .rdata (mem_rdata)
  );

  // In fall-through mode the head is masked while empty so reset/empty show zero.
  assign rdata        = (FWFT && !rvalid_q) ? '0 : mem_rdata;
  assign rvalid       = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - directed self-checking bench for fifo_sync_flags (both read modes)
module tb_fifo_sync_flags;

`ifdef FIFO_SYNC_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_sync_flags dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .wdata        (wdata),
    .r_en         (r_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    w_en = w; wdata = d; r_en = r; clr_err = c;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic fill16();
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({full, empty, almost_full, almost_empty, rvalid, overflow, underflow} !== 7'b0101000) begin
      n_fail++;
      $display("FAIL reset_flags: got f=%b e=%b af=%b ae=%b rv=%b ov=%b uf=%b, want 0 1 0 1 0 0 0",
               full, empty, almost_full, almost_empty, rvalid, overflow, underflow);
    end
    n_tests++;
    if (count !== 5'd0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_count_rdata: got count=%0d rdata=%h, want 0 00", count, rdata);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      n_tests++;
      if (count !== 5'(i) || full !== (i == 16) || almost_full !== (i >= 14) ||
          almost_empty !== (i <= 2) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: got count=%0d f=%b af=%b ae=%b e=%b, want %0d %b %b %b 0",
                 i, count, full, almost_full, almost_empty, empty, i, (i == 16), (i >= 14), (i <= 2));
      end
    end
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_set: got ov=%b count=%0d f=%b uf=%b, want 1 16 1 0", overflow, count, full, underflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow_clear: got ov=%b count=%0d, want 0 16", overflow, count);
    end
  endtask

  task automatic test_drain();
    apply_reset();
    fill16();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++;
      if (rdata !== 8'(i) || rvalid !== 1'b1 || count !== 5'(16 - i) || empty !== (i == 16)) begin
        n_fail++;
        $display("FAIL drain_%0d: got rdata=%h rv=%b count=%0d e=%b, want %h 1 %0d %b",
                 i, rdata, rvalid, count, empty, 8'(i), 16 - i, (i == 16));
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (underflow !== 1'b1 || rdata !== 8'h10 || rvalid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow_set: got uf=%b rdata=%h rv=%b count=%0d, want 1 10 0 0", underflow, rdata, rvalid, count);
    end
  endtask

  task automatic test_pass_full();
    logic [7:0] exp [0:15];
    apply_reset();
    fill16();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 8'hA0 + 8'(k), 1'b1, 1'b0);
      n_tests++;
      if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0 || rdata !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL pass_full_%0d: got f=%b count=%0d ov=%b rdata=%h, want 1 16 0 %h",
                 k, full, count, overflow, rdata, 8'(k + 1));
      end
    end
    for (int i = 0; i < 12; i++) exp[i] = 8'(i + 5);
    for (int i = 0; i < 4; i++)  exp[12 + i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++;
      if (rdata !== exp[i]) begin
        n_fail++;
        $display("FAIL pass_full_order_%0d: got %h, want %h", i, rdata, exp[i]);
      end
    end
  endtask

  task automatic test_empty_rw();
    apply_reset();
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    n_tests++;
    if (count !== 5'd1 || underflow !== 1'b1 || empty !== 1'b0 || rvalid !== FWFT) begin
      n_fail++;
      $display("FAIL empty_rw: got count=%0d uf=%b e=%b rv=%b, want 1 1 0 %b", count, underflow, empty, rvalid, FWFT);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: got %b, want 0", underflow);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || (!FWFT && rdata !== 8'h77)) begin
      n_fail++;
      $display("FAIL empty_rw_pop: got count=%0d e=%b rdata=%h, want 0 1 77", count, empty, rdata);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    n_tests++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_set_wins: got %b, want 1", underflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear2: got %b, want 0", underflow);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    int wr = 0, rd = 0, mc = 0, cyc = 0;
    logic w, r;
    apply_reset();
    while ((wr < 40 || rd < 40) && cyc < 2000) begin
      cyc++;
      w = (wr < 40) && (mc < 16) && ($urandom_range(0, 2) != 0);
      r = (mc > 0) && ($urandom_range(0, 2) != 0);
      exp_d = 8'h00;
      if (FWFT && mc > 0) begin
        n_tests++;
        if (rdata !== q[0] || rvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_head_%0d: got rdata=%h rv=%b, want %h 1", rd, rdata, rvalid, q[0]);
        end
      end
      if (r) exp_d = q.pop_front();
      if (w) q.push_back(8'(wr * 7 + 3));
      cycle(w, 8'(wr * 7 + 3), r, 1'b0);
      if (w) wr++;
      if (r) rd++;
      mc = wr - rd;
      n_tests++;
      if (count !== 5'(mc) || (!FWFT && r && (rdata !== exp_d || rvalid !== 1'b1))) begin
        n_fail++;
        $display("FAIL wrap_cycle_%0d: got count=%0d rdata=%h rv=%b, want %0d %h", cyc, count, rdata, rvalid, mc, exp_d);
      end
    end
    n_tests++;
    if (wr != 40 || rd != 40 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: got wr=%0d rd=%0d ov=%b uf=%b, want 40 40 0 0", wr, rd, overflow, underflow);
    end
  endtask

  task automatic test_fwft();
    apply_reset();
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    n_tests++;
    if (rdata !== 8'h55 || rvalid !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_present: got rdata=%h rv=%b e=%b, want 55 1 0", rdata, rvalid, empty);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (empty !== 1'b1 || rvalid !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_ack: got e=%b rv=%b uf=%b, want 1 0 0", empty, rvalid, underflow);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    w_en = 1'b1; wdata = 8'h44; r_en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({full, empty, almost_full, almost_empty, rvalid, overflow, underflow} !== 7'b0101000 ||
        count !== 5'd0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got f=%b e=%b af=%b ae=%b rv=%b ov=%b uf=%b count=%0d rdata=%h, want 0 1 0 1 0 0 0 0 00",
               full, empty, almost_full, almost_empty, rvalid, overflow, underflow, count, rdata);
    end
    w_en = 1'b0; r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    if (!FWFT) begin
      test_drain();
      test_pass_full();
    end else begin
      test_fwft();
    end
    test_empty_rw();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised single-clock FIFO; successor to the team's fixed 4x4 synchronous FIFO.
- Adds:
  - threshold flags (almost_full / almost_empty);
  - occupancy count;
  - sticky overflow/underflow error flags with clear;
  - defined simultaneous read/write at full/empty;
  - optional first-word-fall-through read mode.
- Sits between a producer and consumer in the same clock domain; used as the generic buffering block for stream datapaths.

Parameters:
- MEMORY_WIDTH, 8: data word width in bits.
- MEMORY_DEPTH, 16: number of entries; power of two, >= 4.
- ADDRESS_SIZE, 4: log2(MEMORY_DEPTH); pointers are ADDRESS_SIZE+1 bits wide (extra wrap bit).
- ALMOST_FULL_TH, 14: almost_full asserted when count >= this value; range 1..MEMORY_DEPTH.
- ALMOST_EMPTY_TH, 2: almost_empty asserted when count <= this value; range 0..MEMORY_DEPTH-1.

Ports:
- clk, in, 1: single clock; all state updates on rising edge.
- rst, in, 1: reset, asynchronous assert, active-low; release is synchronous to clk upstream.
- w_en, in, 1: write request.
- wdata, in, MEMORY_WIDTH: write data, sampled when the write is accepted.
- r_en, in, 1: read request (pop).
- rdata, out, MEMORY_WIDTH: read data.
- rvalid, out, 1: rdata holds a popped word (standard mode) or a valid head word (FWFT mode).
- full, out, 1: count == MEMORY_DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= ALMOST_FULL_TH.
- almost_empty, out, 1: count <= ALMOST_EMPTY_TH.
- count, out, ADDRESS_SIZE+1: current occupancy, 0..MEMORY_DEPTH.
- overflow, out, 1: sticky; set by a rejected write.
- underflow, out, 1: sticky; set by a rejected read.
- clr_err, in, 1: synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately; no partial transfer completes.
- Write acceptance: wr_acc = w_en & (!full | rd_acc).
  - On acceptance: mem[wr_ptr[ADDRESS_SIZE-1:0]] <= wdata; wr_ptr increments, wrapping modulo 2*MEMORY_DEPTH.
- Read acceptance: rd_acc = r_en & !empty.
  - On acceptance: rd_ptr increments.
  - Write while full is accepted only when a read is accepted in the same cycle (pass-through at full).
  - Read while empty is never accepted, even with a simultaneous write (no bypass).
- Count update, next cycle:
  - count + 1 on write only;
  - count - 1 on read only;
  - unchanged on both or neither.
- Flags: all flag outputs are registered, derived from next-state count, so they are coherent with count in the same cycle. No combinational path from w_en/r_en to flags.
- Standard mode (read latency 1):
  - rd_acc at edge N: rdata = head word and rvalid = 1 after edge N.
  - Without rd_acc: rvalid = 0 after the next edge and rdata holds its last value.
- Errors:
  - overflow set the cycle after w_en & !wr_acc.
  - underflow set the cycle after r_en & empty.
  - Both hold until clr_err = 1 at a rising edge.
  - If a set condition and clr_err occur together, set wins.
  - Rejected accesses change no other state.
- Wrap-around: full is detected as pointer MSBs differing with lower bits equal; empty as pointers equal. Each must match count at every cycle.

Optional Feature:
- Macro: FIFO_SYNC_FWFT_EN.
- Defined (first-word fall-through):
  - rdata continuously presents mem[rd_ptr]; rvalid = !empty (registered with the flags).
  - r_en acts as an acknowledge of the presented word; the next word appears the cycle after.
  - A word written to an empty FIFO appears on rdata one cycle after its write edge.
- Undefined: standard 1-cycle-latency mode as in Behaviour.
- Flags, count and errors are identical in both modes.

Decomposition:
- Shared package/include (fifo_pkg) holds:
  - the clog2 helper used to check ADDRESS_SIZE == log2(MEMORY_DEPTH), via an elaboration-time error;
  - the default width/depth constants;
  - the threshold range checks.
- One sub-module: fifo_mem_dp, a simple dual-port RAM with registered write, and a read port that is registered (standard) or asynchronous (FWFT), selected by a parameter passed from the top.
- Pointer, count, flag and error logic stay in fifo_sync_flags.

Test Plan (defaults, depth 16):
- Reset, then 16 writes of 0x01..0x10:
  - full = 1 after the 16th edge;
  - almost_full = 1 from count = 14;
  - count = 16;
  - a 17th write sets overflow and count stays 16.
- Read 16 words in standard mode:
  - rdata = 0x01..0x10 in order, each one cycle after its r_en edge, rvalid = 1;
  - empty = 1 after the last read;
  - an extra read sets underflow and rdata holds 0x10.
- With count = 16, assert w_en and r_en together for 4 cycles (data 0xA0..0xA3): full stays 1, count = 16, no overflow, and the read order is preserved.
- With count = 0, assert w_en and r_en together: the write is accepted, the read is rejected, underflow = 1, count = 1. Then clr_err clears underflow, but not if r_en & empty in the same cycle.
- Wrap test: 40 writes and reads interleaved with random gaps; the scoreboard matches all data across 2+ pointer wraps, and count always equals writes minus reads.
- FIFO_SYNC_FWFT_EN build: write 0x55 into an empty FIFO; rdata = 0x55 and rvalid = 1 one cycle later without r_en; after r_en, empty = 1 and rvalid = 0. Assert rst low mid-burst: all outputs reach their reset values immediately.
